// File: rtl/tt_input_conditioner.sv
// tt_input_conditioner: per-pin 2-flop synchronizer plus counter debounce with optional edge strobes.
// Define INPUT_EDGE_DETECT_EN to build rise_pulse/fall_pulse/changed; otherwise they are tied to 0.
module tt_input_conditioner #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 2080
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] ui_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             changed
);
   localparam logic [11:0] LAST = 12'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]       s1_q, s1_d, s2_q, s2_d, st_q, st_d;
   logic [WIDTH-1:0][11:0] cnt_q, cnt_d;

   always_comb begin
      s1_d  = pin_in;
      s2_d  = s1_q;
      st_d  = st_q;
      cnt_d = cnt_q;
      if (ena) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == st_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
               st_d[i]  = s2_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 12'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q  <= '0;
         s2_q  <= '0;
         st_q  <= '0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   assign ui_out = st_q;

`ifdef INPUT_EDGE_DETECT_EN
   logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;

   // st only moves on an accepted level, so its next-state difference is the strobe
   always_comb begin
      rise_d = st_d & ~st_q;
      fall_d = ~st_d & st_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign changed    = |(rise_q | fall_q);
`else
   assign rise_pulse = '0;
   assign fall_pulse = '0;
   assign changed    = 1'b0;
`endif
endmodule

// File: tb/tb_tt_input_conditioner.sv
// tb_tt_input_conditioner: directed plus random stimulus, scoreboard queue checked by a monitor.
module tb_tt_input_conditioner;
   localparam int W  = 8;
   localparam int DC = 4;

   typedef struct packed {
      logic [W-1:0] ui;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         chg;
   } obs_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b1;
   logic [W-1:0] pin_in = '0;
   logic [W-1:0] ui_out, rise_pulse, fall_pulse;
   logic         changed;

   int    checks = 0;
   int    failures = 0;
   string phase = "reset";
   obs_t  sbq[$];

   // reference: sampled pin history, accepted level, run length of disagreeing enabled samples
   logic [W-1:0] hist[$];
   logic [W-1:0] lvl;
   int           run[W];

   tt_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .pin_in(pin_in),
      .ui_out(ui_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .changed(changed)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [W-1:0] p, input logic e, input logic r);
      obs_t         x;
      logic [W-1:0] seen;
      @(negedge clk);
      pin_in = p;
      ena    = e;
      rst_n  = r;
      x = '0;
      if (!r) begin
         hist = {};
         lvl  = '0;
         for (int i = 0; i < W; i++) run[i] = 0;
      end else begin
         seen = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
         if (e) begin
            for (int i = 0; i < W; i++) begin
               if (seen[i] != lvl[i]) begin
                  run[i] = run[i] + 1;
                  if (run[i] == DC) begin
                     lvl[i]    = seen[i];
                     x.rise[i] = seen[i];
                     x.fall[i] = !seen[i];
                     run[i]    = 0;
                  end
               end else begin
                  run[i] = 0;
               end
            end
         end
         hist.push_back(p);
         if (hist.size() > 2) void'(hist.pop_front());
      end
      x.ui  = lvl;
      x.chg = |(x.rise | x.fall);
`ifndef INPUT_EDGE_DETECT_EN
      x.rise = '0;
      x.fall = '0;
      x.chg  = 1'b0;
`endif
      sbq.push_back(x);
   endtask

   task automatic hold(input logic [W-1:0] p, input logic e, input int n);
      for (int k = 0; k < n; k++) step(p, e, 1'b1);
   endtask

   initial begin : monitor
      obs_t x, g;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() != 0) begin
            x = sbq.pop_front();
            g = {ui_out, rise_pulse, fall_pulse, changed};
            checks++;
            if (g !== x) begin
               failures++;
               $display("FAIL %s t=%0t ui=%h/%h rise=%h/%h fall=%h/%h chg=%b/%b (got/exp)",
                        phase, $time, g.ui, x.ui, g.rise, x.rise, g.fall, x.fall, g.chg, x.chg);
            end
         end
      end
   end

   initial begin : stim
      logic [W-1:0] p;
      for (int k = 0; k < 3; k++) step(8'hFF, 1'b1, 1'b0);
      phase = "reset_release";
      hold(8'hFF, 1'b1, 10);
      phase = "glitch";
      hold(8'h00, 1'b1, 10);
      hold(8'h01, 1'b1, 3);
      hold(8'h00, 1'b1, 10);
      hold(8'h01, 1'b1, 4);
      hold(8'h00, 1'b1, 12);
      phase = "hold";
      hold(8'h08, 1'b0, 20);
      hold(8'h08, 1'b1, 10);
      phase = "simultaneous";
      hold(8'h0F, 1'b1, 10);
      hold(8'hF0, 1'b1, 10);
      phase = "reset_mid";
      hold(8'h0F, 1'b1, 4);
      step(8'h0F, 1'b1, 1'b0);
      step(8'h0F, 1'b1, 1'b0);
      hold(8'h0F, 1'b1, 10);
      phase = "random";
      p = 8'h0F;
      for (int k = 0; k < 3000; k++) begin
         p = p ^ W'($urandom & $urandom & $urandom);
         step(p, $urandom_range(0, 9) != 0, $urandom_range(0, 199) != 0);
      end
      phase = "drain";
      repeat (3) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tt_input_conditioner.md
TT_INPUT_CONDITIONER -- requirements
Module: tt_input_conditioner

Interface
REQ-001 Parameter WIDTH, default 8: number of conditioned input pins.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2080: consecutive stable cycles required to accept a new level (1 ms at 2.08 MHz); legal range 1..4095.
REQ-003 Port clk  input  1: single clock (on-chip oscillator); all logic on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port ena  input  1: high = debounce counters run; low = hold.
REQ-006 Port pin_in  input  WIDTH: raw asynchronous board pins.
REQ-007 Port ui_out  output  WIDTH: synchronized, debounced levels; drives the design's ui_in.
REQ-008 Port rise_pulse  output  WIDTH: one-cycle strobe per bit on an accepted 0->1.
REQ-009 Port fall_pulse  output  WIDTH: one-cycle strobe per bit on an accepted 1->0.
REQ-010 Port changed  output  1: OR-reduction of rise_pulse and fall_pulse.

Function
REQ-011 Each bit of pin_in passes through a 2-flop synchronizer (s1, s2); s1/s2 update every cycle regardless of ena.
REQ-012 Each bit has an independent 12-bit counter cnt and a stable register st; ui_out[i] = st[i].
REQ-013 If ena=1 and s2[i]!=st[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i] increments.
REQ-014 If ena=1 and s2[i]!=st[i] and cnt[i]==DEBOUNCE_CYCLES-1: st[i]<=s2[i], cnt[i]<=0 in the same cycle.
REQ-015 If ena=1 and s2[i]==st[i]: cnt[i]<=0 (any glitch shorter than DEBOUNCE_CYCLES restarts qualification).
REQ-016 If ena=0: cnt and st hold; rise_pulse, fall_pulse, changed are 0.
REQ-017 cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
REQ-018 Latency: new pin level held steady is visible on ui_out exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it into s1 (ena=1 throughout).
REQ-019 rise_pulse[i]/fall_pulse[i] are registered, asserted for exactly one cycle, coincident with the first cycle ui_out[i] shows the new level.
REQ-020 Multiple bits qualifying in the same cycle produce simultaneous pulses; changed asserts once for that cycle.
REQ-021 A bit never produces both rise and fall pulses in the same cycle.

Reset
REQ-022 While rst_n=0 at a clock edge: s1, s2, st, cnt, ui_out, rise_pulse, fall_pulse, changed all <= 0.
REQ-023 Reset mid-qualification discards partial counts; no pulse is emitted on reset entry or exit.
REQ-024 Pins held high through reset release produce a normal rise_pulse after the REQ-018 latency.

Configuration
REQ-025 Macro INPUT_EDGE_DETECT_EN defined: rise_pulse, fall_pulse, changed behave per REQ-019..021.
REQ-026 Macro INPUT_EDGE_DETECT_EN undefined: edge registers are not built; rise_pulse, fall_pulse, changed are constant 0; ui_out behaviour unchanged.

Verification (bench uses WIDTH=8, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-027 Reset: rst_n=0 for 3 cycles with pin_in=8'hFF -> all outputs 0; after release ui_out=8'hFF at edge 6 and rise_pulse=8'hFF for exactly 1 cycle, changed=1.
REQ-028 Glitch: pin_in[0] high for 3 cycles then low -> ui_out[0] stays 0, no pulses; high for 4 cycles -> ui_out[0]=1 after 6 edges, rise_pulse[0] one cycle.
REQ-029 Hold: ena=0 during a pin_in[3] 0->1 transition for 20 cycles -> ui_out[3] stays 0; ena=1 -> ui_out[3]=1 after 4 further edges.
REQ-030 Simultaneous: pin_in 8'h0F->8'hF0 stepped together -> after 6 edges ui_out=8'hF0, rise_pulse=8'hF0, fall_pulse=8'h0F same cycle, changed high 1 cycle.
REQ-031 Reset mid-count: rst_n=0 when cnt=2 -> cnt cleared, no pulse; qualification restarts full 4 cycles after release.
REQ-032 Macro undefined: repeat REQ-030 -> ui_out identical, rise_pulse=fall_pulse=0, changed=0 throughout.
